// File: rtl/apb_decode_pkg.sv
// Shared types and constants for the APB address-decode / timeout fabric stage.
// Holds the FSM state encoding, the timeout counter width and the error read data.
// Imported by apb_decode_timeout.
package apb_decode_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } decode_state_t;

  localparam int TIMEOUT_CNT_WIDTH = 16;
  localparam int ERR_RDATA         = 0;

endpackage

// File: rtl/apb_decode_timeout.sv
// APB fabric stage: decodes upstream address to one of NUM_PORTS completers, re-issues SETUP/ACCESS.
// Latency: 3 cycles for a zero-wait completer (+1 per wait state), 1 cycle for a decode error.
// Backpressure: upstream held off until RESP; hung completers aborted after TIMEOUT ACCESS cycles.
module apb_decode_timeout
  import apb_decode_pkg::*;
#(
  parameter int NUM_PORTS  = 8,
  parameter int BLOCK_SIZE = 1024,
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  localparam int LOW_WIDTH  = $clog2(BLOCK_SIZE),
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                                 pclk,
  input  logic                                 preset_n,
  // upstream completer side (from the management bridge)
  input  logic                                 psel,
  input  logic                                 penable,
  input  logic                                 pwrite,
  input  logic [ADDR_WIDTH-1:0]                paddr,
  input  logic [DATA_WIDTH-1:0]                pwdata,
  input  logic [STRB_WIDTH-1:0]                pstrb,
  input  logic [2:0]                           pprot,
  output logic [DATA_WIDTH-1:0]                prdata,
  output logic                                 pready,
  output logic                                 pslverr,
  // downstream requester side, one bus per completer
  output logic [NUM_PORTS-1:0]                 ds_pclk,
  output logic [NUM_PORTS-1:0]                 ds_preset_n,
  output logic [NUM_PORTS-1:0]                 ds_psel,
  output logic [NUM_PORTS-1:0]                 ds_penable,
  output logic [NUM_PORTS-1:0]                 ds_pwakeup,
  output logic [LOW_WIDTH-1:0]                 ds_paddr,
  output logic                                 ds_pwrite,
  output logic [DATA_WIDTH-1:0]                ds_pwdata,
  output logic [STRB_WIDTH-1:0]                ds_pstrb,
  output logic [2:0]                           ds_pprot,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] ds_prdata,
  input  logic [NUM_PORTS-1:0]                 ds_pready,
  input  logic [NUM_PORTS-1:0]                 ds_pslverr,
  // error reporting
  output logic [TIMEOUT_CNT_WIDTH-1:0]         timeout_count,
  output logic [ADDR_WIDTH-1:0]                err_addr,
  output logic                                 err_pulse
);

  localparam int IDX_WIDTH = ADDR_WIDTH - LOW_WIDTH;
  localparam logic [31:0] NUM_PORTS_U = NUM_PORTS;
  localparam logic [TIMEOUT_CNT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERR_RDATA);

  decode_state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0]        req_addr_q;
  logic                         req_write_q;
  logic [DATA_WIDTH-1:0]        req_wdata_q;
  logic [STRB_WIDTH-1:0]        req_strb_q;
  logic [2:0]                   req_prot_q;
  logic [NUM_PORTS-1:0]         sel_q, sel_d;
  logic [NUM_PORTS-1:0]         en_q, en_d;
  logic [TIMEOUT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic                         pready_d, pslverr_d, err_pulse_d;
  logic [DATA_WIDTH-1:0]        prdata_d;
  logic [ADDR_WIDTH-1:0]        err_addr_d;
  logic                         capture, is_timeout;

  logic [IDX_WIDTH-1:0]         req_idx;
  logic [DATA_WIDTH-1:0]        sel_rdata;
  logic                         sel_ready, sel_err;

  assign req_idx = paddr[ADDR_WIDTH-1:LOW_WIDTH];

  // Response mux from whichever completer is currently selected (one-hot sel_q).
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel_q[i]) begin
        sel_rdata = sel_rdata | ds_prdata[i];
        sel_ready = sel_ready | ds_pready[i];
        sel_err   = sel_err   | ds_pslverr[i];
      end
    end
  end

  // Next-state and next-output logic; every output is computed here and registered below.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    en_d        = en_q;
    wait_cnt_d  = wait_cnt_q;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    prdata_d    = '0;
    err_pulse_d = 1'b0;
    err_addr_d  = err_addr;
    capture     = 1'b0;
    is_timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && penable) begin
          capture = 1'b1;
          if (32'(req_idx) < NUM_PORTS_U) begin
            state_d = SETUP;
            for (int i = 0; i < NUM_PORTS; i++) begin
              sel_d[i] = (req_idx == IDX_WIDTH'(i));
            end
          end else begin
            // Unmapped address: answer with an error without touching any completer.
            state_d     = RESP;
            pready_d    = 1'b1;
            pslverr_d   = 1'b1;
            prdata_d    = ERR_DATA;
            err_pulse_d = 1'b1;
            err_addr_d  = paddr;
          end
        end
      end
      SETUP: begin
        state_d    = ACCESS;
        en_d       = sel_q;
        wait_cnt_d = '0;
      end
      ACCESS: begin
        // A ready in the final permitted cycle takes priority over the timeout.
        if (sel_ready) begin
          state_d   = RESP;
          sel_d     = '0;
          en_d      = '0;
          pready_d  = 1'b1;
          pslverr_d = sel_err;
          prdata_d  = sel_rdata;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          state_d     = RESP;
          sel_d       = '0;
          en_d        = '0;
          pready_d    = 1'b1;
          pslverr_d   = 1'b1;
          prdata_d    = ERR_DATA;
          err_pulse_d = 1'b1;
          err_addr_d  = req_addr_q;
          is_timeout  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        en_d    = '0;
      end
    endcase
  end

  // State, request latch, downstream strobes and upstream response registers.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q       <= IDLE;
      req_addr_q    <= '0;
      req_write_q   <= 1'b0;
      req_wdata_q   <= '0;
      req_strb_q    <= '0;
      req_prot_q    <= '0;
      sel_q         <= '0;
      en_q          <= '0;
      wait_cnt_q    <= '0;
      pready        <= 1'b0;
      pslverr       <= 1'b0;
      prdata        <= '0;
      err_pulse     <= 1'b0;
      err_addr      <= '0;
      timeout_count <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      en_q       <= en_d;
      wait_cnt_q <= wait_cnt_d;
      pready     <= pready_d;
      pslverr    <= pslverr_d;
      prdata     <= prdata_d;
      err_pulse  <= err_pulse_d;
      err_addr   <= err_addr_d;
      if (capture) begin
        req_addr_q  <= paddr;
        req_write_q <= pwrite;
        req_wdata_q <= pwdata;
        req_strb_q  <= pstrb;
        req_prot_q  <= pprot;
      end
      if (is_timeout && (timeout_count != '1)) begin
        timeout_count <= timeout_count + 1'b1;
      end
    end
  end

  // Shared request fields go to every completer; only psel/penable are per port.
  assign ds_paddr  = req_addr_q[LOW_WIDTH-1:0];
  assign ds_pwrite = req_write_q;
  assign ds_pwdata = req_wdata_q;
  assign ds_pstrb  = req_strb_q;
  assign ds_pprot  = req_prot_q;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign ds_pclk[g]     = pclk;
    assign ds_preset_n[g] = preset_n;
    assign ds_psel[g]     = sel_q[g];
    assign ds_penable[g]  = en_q[g];
    assign ds_pwakeup[g]  = 1'b0;
  end

endmodule

// File: tb/tb_apb_decode_timeout.sv
// Directed bench for apb_decode_timeout: reads, writes, decode errors, timeouts, reset abort.
// Each scenario task drives one upstream transfer and checks against hand-computed values.
// TIMEOUT is set to 4 so timeout scenarios stay short.
module tb_apb_decode_timeout;

  logic               pclk;
  logic               preset_n;
  logic               psel, penable, pwrite;
  logic [23:0]        paddr;
  logic [31:0]        pwdata;
  logic [3:0]         pstrb;
  logic [2:0]         pprot;
  logic [31:0]        prdata;
  logic               pready, pslverr;
  logic [7:0]         ds_pclk, ds_preset_n, ds_psel, ds_penable, ds_pwakeup;
  logic [9:0]         ds_paddr;
  logic               ds_pwrite;
  logic [31:0]        ds_pwdata;
  logic [3:0]         ds_pstrb;
  logic [2:0]         ds_pprot;
  logic [7:0][31:0]   ds_prdata;
  logic [7:0]         ds_pready, ds_pslverr;
  logic [15:0]        timeout_count;
  logic [23:0]        err_addr;
  logic               err_pulse;

  int checks = 0;
  int errors = 0;

  // observations from the most recent transfer
  int          obs_lat, obs_setup, obs_access, obs_wrong;
  logic        obs_setup_first, obs_serr, obs_epulse, obs_psel_resp, obs_pulse_after, obs_pready_after;
  logic [31:0] obs_rd, obs_pwdata;
  logic [23:0] obs_eaddr;
  logic [9:0]  obs_paddr;
  logic        obs_pwrite;
  logic [3:0]  obs_pstrb;

  apb_decode_timeout #(
    .NUM_PORTS(8), .BLOCK_SIZE(1024), .ADDR_WIDTH(24), .DATA_WIDTH(32), .TIMEOUT(4)
  ) dut (
    .pclk(pclk), .preset_n(preset_n),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .ds_pclk(ds_pclk), .ds_preset_n(ds_preset_n), .ds_psel(ds_psel), .ds_penable(ds_penable),
    .ds_pwakeup(ds_pwakeup), .ds_paddr(ds_paddr), .ds_pwrite(ds_pwrite), .ds_pwdata(ds_pwdata),
    .ds_pstrb(ds_pstrb), .ds_pprot(ds_pprot), .ds_prdata(ds_prdata), .ds_pready(ds_pready),
    .ds_pslverr(ds_pslverr), .timeout_count(timeout_count), .err_addr(err_addr),
    .err_pulse(err_pulse)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Issue one upstream transfer; the completer model answers after ws wait states.
  task automatic run_xfer(input logic [23:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int ws, input logic serr_in,
                          input logic [31:0] rdata_in);
    logic [7:0] tmask;
    int acc;
    logic seen;
    tmask = (addr[23:10] < 14'd8) ? (8'd1 << addr[12:10]) : 8'd0;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb; pprot = 3'd0;
    for (int p = 0; p < 8; p++) ds_prdata[p] = tmask[p] ? rdata_in : {16'hDEAD, 16'(p)};
    ds_pready = '0; ds_pslverr = '0;
    acc = 0; seen = 1'b0;
    obs_lat = -1; obs_setup = 0; obs_access = 0; obs_wrong = 0; obs_setup_first = 1'b0;
    obs_rd = '0; obs_serr = 1'b0; obs_epulse = 1'b0; obs_eaddr = '0; obs_psel_resp = 1'b0;
    obs_paddr = '0; obs_pwdata = '0; obs_pwrite = 1'b0; obs_pstrb = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge pclk); #1;
      if (ds_psel != 8'd0) begin
        if (ds_psel != tmask) obs_wrong++;
        if (!seen) begin
          seen = 1'b1;
          obs_setup_first = (ds_penable == 8'd0);
          obs_paddr = ds_paddr; obs_pwdata = ds_pwdata; obs_pwrite = ds_pwrite; obs_pstrb = ds_pstrb;
        end
        if (ds_penable == 8'd0) obs_setup++; else obs_access++;
      end
      if (ds_penable != 8'd0) acc++; else acc = 0;
      ds_pready  = (acc > ws) ? tmask : 8'd0;
      ds_pslverr = (acc > ws && serr_in) ? tmask : 8'd0;
      if (pready) begin
        obs_lat = c; obs_rd = prdata; obs_serr = pslverr; obs_epulse = err_pulse;
        obs_eaddr = err_addr; obs_psel_resp = |ds_psel;
        break;
      end
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; ds_pready = '0; ds_pslverr = '0;
    obs_pulse_after = err_pulse; obs_pready_after = pready;
  endtask

  task automatic test_reset();
    preset_n = 1'b0;
    repeat (2) @(posedge pclk); #1;
    checks++; if ({pready, pslverr, err_pulse} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {pready, pslverr, err_pulse}); end
    checks++; if (prdata !== 32'd0) begin errors++; $display("FAIL reset_prdata got %h want 0", prdata); end
    checks++; if ((ds_psel | ds_penable) !== 8'd0) begin errors++; $display("FAIL reset_ds_sel got %h want 00", ds_psel | ds_penable); end
    checks++; if ({timeout_count, err_addr} !== 40'd0) begin errors++; $display("FAIL reset_err_regs got %h want 0", {timeout_count, err_addr}); end
    checks++; if (ds_pwakeup !== 8'd0) begin errors++; $display("FAIL reset_pwakeup got %h want 00", ds_pwakeup); end
    @(negedge pclk); preset_n = 1'b1;
  endtask

  task automatic test_read_zero_wait();
    run_xfer(24'h000804, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h12345678);
    checks++; if (obs_lat !== 3) begin errors++; $display("FAIL read_latency got %0d want 3", obs_lat); end
    checks++; if (obs_rd !== 32'h12345678) begin errors++; $display("FAIL read_prdata got %h want 12345678", obs_rd); end
    checks++; if ({obs_serr, obs_epulse} !== 2'b00) begin errors++; $display("FAIL read_err got %b want 00", {obs_serr, obs_epulse}); end
    checks++; if (obs_paddr !== 10'h004) begin errors++; $display("FAIL read_ds_paddr got %h want 004", obs_paddr); end
    checks++; if ({obs_setup_first, obs_setup, obs_access, obs_wrong} !== {1'b1, 32'd1, 32'd1, 32'd0}) begin errors++; $display("FAIL read_phases got first=%b setup=%0d access=%0d wrong=%0d want 1 1 1 0", obs_setup_first, obs_setup, obs_access, obs_wrong); end
    checks++; if (obs_pready_after !== 1'b0) begin errors++; $display("FAIL read_pready_one_cycle got %b want 0", obs_pready_after); end
  endtask

  task automatic test_write_wait();
    run_xfer(24'h000010, 1'b1, 32'hCAFEBABE, 4'hF, 2, 1'b0, 32'h0);
    checks++; if (obs_lat !== 5) begin errors++; $display("FAIL write_latency got %0d want 5", obs_lat); end
    checks++; if ({obs_pwrite, obs_pwdata, obs_pstrb, obs_paddr} !== {1'b1, 32'hCAFEBABE, 4'hF, 10'h010}) begin errors++; $display("FAIL write_ds_fields got %b %h %h %h want 1 cafebabe f 010", obs_pwrite, obs_pwdata, obs_pstrb, obs_paddr); end
    checks++; if ({obs_setup, obs_access, obs_wrong} !== {32'd1, 32'd3, 32'd0}) begin errors++; $display("FAIL write_phases got setup=%0d access=%0d wrong=%0d want 1 3 0", obs_setup, obs_access, obs_wrong); end
    checks++; if (obs_serr !== 1'b0) begin errors++; $display("FAIL write_pslverr got %b want 0", obs_serr); end
  endtask

  task automatic test_decode_error();
    run_xfer(24'h002000, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h0);
    checks++; if (obs_lat !== 1) begin errors++; $display("FAIL decode_latency got %0d want 1", obs_lat); end
    checks++; if ((obs_setup + obs_access) !== 0) begin errors++; $display("FAIL decode_no_psel got %0d want 0", obs_setup + obs_access); end
    checks++; if ({obs_serr, obs_rd} !== {1'b1, 32'd0}) begin errors++; $display("FAIL decode_resp got %b %h want 1 00000000", obs_serr, obs_rd); end
    checks++; if (obs_eaddr !== 24'h002000) begin errors++; $display("FAIL decode_err_addr got %h want 002000", obs_eaddr); end
    checks++; if ({obs_epulse, obs_pulse_after} !== 2'b10) begin errors++; $display("FAIL decode_err_pulse got %b want 10", {obs_epulse, obs_pulse_after}); end
    checks++; if (timeout_count !== 16'd0) begin errors++; $display("FAIL decode_timeout_count got %h want 0000", timeout_count); end
  endtask

  task automatic test_timeout();
    run_xfer(24'h000C08, 1'b0, 32'h0, 4'h0, 1000, 1'b0, 32'hBADBAD00);
    checks++; if (obs_lat !== 6) begin errors++; $display("FAIL timeout_latency got %0d want 6", obs_lat); end
    checks++; if ({obs_access, obs_wrong} !== {32'd4, 32'd0}) begin errors++; $display("FAIL timeout_access_cycles got %0d wrong=%0d want 4 0", obs_access, obs_wrong); end
    checks++; if (obs_psel_resp !== 1'b0) begin errors++; $display("FAIL timeout_psel_drop got %b want 0", obs_psel_resp); end
    checks++; if ({obs_serr, obs_rd, obs_epulse} !== {1'b1, 32'd0, 1'b1}) begin errors++; $display("FAIL timeout_resp got %b %h %b want 1 00000000 1", obs_serr, obs_rd, obs_epulse); end
    checks++; if ({timeout_count, obs_eaddr} !== {16'd1, 24'h000C08}) begin errors++; $display("FAIL timeout_count_addr got %h %h want 0001 000c08", timeout_count, obs_eaddr); end
  endtask

  task automatic test_late_ready();
    run_xfer(24'h000420, 1'b0, 32'h0, 4'h0, 3, 1'b1, 32'h0BADF00D);
    checks++; if (obs_lat !== 6) begin errors++; $display("FAIL late_latency got %0d want 6", obs_lat); end
    checks++; if ({obs_serr, obs_rd} !== {1'b1, 32'h0BADF00D}) begin errors++; $display("FAIL late_resp got %b %h want 1 0badf00d", obs_serr, obs_rd); end
    checks++; if ({obs_epulse, timeout_count} !== {1'b0, 16'd1}) begin errors++; $display("FAIL late_no_timeout got %b %h want 0 0001", obs_epulse, timeout_count); end
    checks++; if (err_addr !== 24'h000C08) begin errors++; $display("FAIL late_err_addr got %h want 000c08", err_addr); end
  endtask

  task automatic test_saturation();
    @(posedge pclk); #1;
    force dut.timeout_count = 16'hFFFE;
    #1;
    release dut.timeout_count;
    run_xfer(24'h001C00, 1'b0, 32'h0, 4'h0, 1000, 1'b0, 32'h0);
    checks++; if (timeout_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h want ffff", timeout_count); end
    run_xfer(24'h001C00, 1'b0, 32'h0, 4'h0, 1000, 1'b0, 32'h0);
    checks++; if ({timeout_count, obs_serr} !== {16'hFFFF, 1'b1}) begin errors++; $display("FAIL sat_hold got %h %b want ffff 1", timeout_count, obs_serr); end
  endtask

  task automatic test_reset_mid_access();
    logic in_access;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 24'h001404; ds_pready = '0; ds_pslverr = '0;
    repeat (2) @(posedge pclk); #1;
    in_access = (ds_penable == 8'h20);
    checks++; if (in_access !== 1'b1) begin errors++; $display("FAIL rst_reach_access got %h want 20", ds_penable); end
    #2; preset_n = 1'b0;
    #1;
    checks++; if ({ds_psel, ds_penable, pready} !== 17'd0) begin errors++; $display("FAIL rst_async_clear got %h want 0", {ds_psel, ds_penable, pready}); end
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk); preset_n = 1'b1;
    run_xfer(24'h001404, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'hA5A55A5A);
    checks++; if ({obs_lat, obs_rd, obs_serr} !== {32'd3, 32'hA5A55A5A, 1'b0}) begin errors++; $display("FAIL rst_after_read got lat=%0d %h %b want 3 a5a55a5a 0", obs_lat, obs_rd, obs_serr); end
  endtask

  initial begin
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    ds_prdata = '0; ds_pready = '0; ds_pslverr = '0;
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_decode_error();
    test_timeout();
    test_late_ready();
    test_saturation();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
